// File: rtl/if_stage.sv
// Instruction-fetch stage with a one-entry skid buffer.
//
// Fetches from instruction memory at the PC, loads the IF/ID pipeline register
// and honours load-use stalls and EX-stage redirects.
//
// Ports:
//   clk, rstn            clock; synchronous active-low reset
//   Hazard               load-use stall request: hold PC and IF/ID
//   pc_src, pc_target    taken branch/jump from EX: redirect PC and flush IF/ID
//   imem_req, imem_addr  instruction memory request and fetch address (the PC)
//   imem_rdata/ready     fetched instruction and its valid strobe
//   IF_ID_*              IF/ID register contents plus the derived pc+4 and rs fields
//   hazard_cnt           saturating count of cycles stalled by Hazard
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        Hazard,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_pc4,
  output logic [31:0] IF_ID_inst,
  output logic        IF_ID_valid,
  output logic [4:0]  IF_ID_RegisterRs1,
  output logic [4:0]  IF_ID_RegisterRs2,
  output logic [31:0] hazard_cnt
);

  typedef enum logic [1:0] {StBoot, StFetch, StBuffered} state_t;

  state_t      stateQ, stateD;
  logic [31:0] pcQ, pcD;
  logic [31:0] instQ, instD;
  logic [31:0] idPcQ, idPcD;
  logic        validQ, validD;
  logic [31:0] bufInstQ, bufInstD;
  logic [31:0] bufPcQ, bufPcD;
  logic [31:0] cntQ, cntD;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stateQ <= StBoot;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic
  always_comb begin
    stateD = stateQ;
    if (pc_src) begin
      stateD = StFetch;
    end else begin
      unique case (stateQ)
        StBoot:     stateD = StFetch;
        StFetch:    if (imem_ready && Hazard) stateD = StBuffered;
        StBuffered: if (!Hazard) stateD = StFetch;
        default:    stateD = StBoot;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    imem_req  = (stateQ == StFetch);
    imem_addr = pcQ;
  end

  // Datapath next-state
  always_comb begin
    pcD      = pcQ;
    instD    = instQ;
    idPcD    = idPcQ;
    validD   = validQ;
    bufInstD = bufInstQ;
    bufPcD   = bufPcQ;
    if (pc_src) begin
      // Flush: IF/ID pc is kept, only inst/valid turn into a bubble.
      pcD      = {pc_target[31:2], 2'b00};
      instD    = NOP_INST;
      validD   = 1'b0;
      bufInstD = NOP_INST;
      bufPcD   = '0;
    end else begin
      unique case (stateQ)
        StFetch: begin
          if (imem_ready) begin
            pcD = pcQ + 32'd4;
            if (Hazard) begin
              // IF/ID is stalled, so park the returned word in the skid entry.
              bufInstD = imem_rdata;
              bufPcD   = pcQ;
            end else begin
              instD  = imem_rdata;
              idPcD  = pcQ;
              validD = 1'b1;
            end
          end else if (!Hazard) begin
            instD  = NOP_INST;
            validD = 1'b0;
          end
        end
        StBuffered: begin
          if (!Hazard) begin
            instD  = bufInstQ;
            idPcD  = bufPcQ;
            validD = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cntD = cntQ;
    if (Hazard && !pc_src && stateQ != StBoot && cntQ != 32'hFFFF_FFFF) begin
      cntD = cntQ + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pcQ      <= RESET_PC;
      instQ    <= NOP_INST;
      idPcQ    <= '0;
      validQ   <= 1'b0;
      bufInstQ <= NOP_INST;
      bufPcQ   <= '0;
      cntQ     <= '0;
    end else begin
      pcQ      <= pcD;
      instQ    <= instD;
      idPcQ    <= idPcD;
      validQ   <= validD;
      bufInstQ <= bufInstD;
      bufPcQ   <= bufPcD;
      cntQ     <= cntD;
    end
  end

  assign IF_ID_pc          = idPcQ;
  assign IF_ID_pc4         = idPcQ + 32'd4;
  assign IF_ID_inst        = instQ;
  assign IF_ID_valid       = validQ;
  assign IF_ID_RegisterRs1 = instQ[19:15];
  assign IF_ID_RegisterRs2 = instQ[24:20];
  assign hazard_cnt        = cntQ;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk;
  logic        rstn;
  logic        Hazard;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_pc4;
  logic [31:0] IF_ID_inst;
  logic        IF_ID_valid;
  logic [4:0]  IF_ID_RegisterRs1;
  logic [4:0]  IF_ID_RegisterRs2;
  logic [31:0] hazard_cnt;

  int checks = 0;
  int failures = 0;

  if_stage dut (
    .clk               (clk),
    .rstn              (rstn),
    .Hazard            (Hazard),
    .pc_src            (pc_src),
    .pc_target         (pc_target),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .imem_ready        (imem_ready),
    .IF_ID_pc          (IF_ID_pc),
    .IF_ID_pc4         (IF_ID_pc4),
    .IF_ID_inst        (IF_ID_inst),
    .IF_ID_valid       (IF_ID_valid),
    .IF_ID_RegisterRs1 (IF_ID_RegisterRs1),
    .IF_ID_RegisterRs2 (IF_ID_RegisterRs2),
    .hazard_cnt        (hazard_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory returns an address-tagged word so each fetched instruction is traceable.
  function automatic logic [31:0] instOf(input logic [31:0] a);
    return {a[19:0], 12'h033};
  endfunction

  assign imem_rdata = instOf(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkId(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                       input logic valid);
    chk({tag, "_pc"}, IF_ID_pc, pc);
    chk({tag, "_inst"}, IF_ID_inst, inst);
    chk({tag, "_valid"}, {31'd0, IF_ID_valid}, {31'd0, valid});
  endtask

  initial begin
    rstn = 1'b0; Hazard = 1'b0; pc_src = 1'b0; pc_target = '0; imem_ready = 1'b1;
    tick();
    tick();
    // Reset values
    chkId("rst", 32'h0, Nop, 1'b0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h3000);
    chk("rst_cnt", hazard_cnt, 32'd0);
    rstn = 1'b1;
    // First cycle after reset release: still in boot
    chk("boot_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, 32'h3000);
    tick();
    chkId("seq0", 32'h3000, instOf(32'h3000), 1'b1);
    chk("seq0_pc4", IF_ID_pc4, 32'h3004);
    tick();
    chkId("seq1", 32'h3004, instOf(32'h3004), 1'b1);
    chk("seq1_addr", imem_addr, 32'h3008);

    // Two stall cycles with a word returning at 0x3008
    Hazard = 1'b1;
    tick();
    chk("stall0_pc", IF_ID_pc, 32'h3004);
    chk("stall0_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("stall1_pc", IF_ID_pc, 32'h3004);
    chk("stall1_req", {31'd0, imem_req}, 32'd0);
    Hazard = 1'b0;
    tick();
    chkId("unbuf", 32'h3008, instOf(32'h3008), 1'b1);
    chk("unbuf_addr", imem_addr, 32'h300C);
    tick();
    chkId("after_buf", 32'h300C, instOf(32'h300C), 1'b1);
    chk("stall_cnt", hazard_cnt, 32'd2);

    // Redirect from BUFFERED with a misaligned target
    Hazard = 1'b1;
    tick();
    chk("buf2_req", {31'd0, imem_req}, 32'd0);
    chk("buf2_cnt", hazard_cnt, 32'd3);
    pc_src = 1'b1; pc_target = 32'h3103;
    tick();
    chkId("flush", 32'h300C, Nop, 1'b0);
    chk("flush_addr", imem_addr, 32'h3100);
    chk("flush_req", {31'd0, imem_req}, 32'd1);
    chk("flush_cnt", hazard_cnt, 32'd3);
    pc_src = 1'b0; Hazard = 1'b0;
    tick();
    chkId("redir0", 32'h3100, instOf(32'h3100), 1'b1);
    tick();
    chkId("redir1", 32'h3104, instOf(32'h3104), 1'b1);

    // Three memory wait cycles -> three bubbles, PC constant
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chkId("bubble", 32'h3104, Nop, 1'b0);
      chk("bubble_rs1", {27'd0, IF_ID_RegisterRs1}, 32'd0);
      chk("bubble_rs2", {27'd0, IF_ID_RegisterRs2}, 32'd0);
      chk("bubble_addr", imem_addr, 32'h3108);
    end
    imem_ready = 1'b1;
    tick();
    chkId("resume", 32'h3108, instOf(32'h3108), 1'b1);

    // Wait plus stall: everything holds
    imem_ready = 1'b0; Hazard = 1'b1;
    tick();
    chkId("wait_stall", 32'h3108, instOf(32'h3108), 1'b1);
    chk("wait_stall_addr", imem_addr, 32'h310C);
    chk("wait_stall_cnt", hazard_cnt, 32'd4);
    imem_ready = 1'b1; Hazard = 1'b0;
    tick();
    chkId("resume2", 32'h310C, instOf(32'h310C), 1'b1);

    // PC wrap at the top of the address space
    Hazard = 1'b1;
    tick();
    pc_src = 1'b1; pc_target = 32'hFFFF_FFFC;
    tick();
    chk("wrap_target", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_cnt", hazard_cnt, 32'd5);
    pc_src = 1'b0; Hazard = 1'b0;
    tick();
    chkId("wrap", 32'hFFFF_FFFC, instOf(32'hFFFF_FFFC), 1'b1);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc4", IF_ID_pc4, 32'h0);

    // Aligned redirect from BUFFERED
    Hazard = 1'b1;
    tick();
    chk("buf3_req", {31'd0, imem_req}, 32'd0);
    pc_src = 1'b1; pc_target = 32'h3100;
    tick();
    chk("flush2_addr", imem_addr, 32'h3100);
    chk("flush2_valid", {31'd0, IF_ID_valid}, 32'd0);
    pc_src = 1'b0;

    // Reset while BUFFERED with a word returning
    tick();
    chk("buf4_req", {31'd0, imem_req}, 32'd0);
    rstn = 1'b0;
    tick();
    chkId("rst2", 32'h0, Nop, 1'b0);
    chk("rst2_req", {31'd0, imem_req}, 32'd0);
    chk("rst2_addr", imem_addr, 32'h3000);
    chk("rst2_cnt", hazard_cnt, 32'd0);
    rstn = 1'b1; Hazard = 1'b0;
    tick();
    chk("rst2_fetch_addr", imem_addr, 32'h3000);
    chk("rst2_fetch_req", {31'd0, imem_req}, 32'd1);
    tick();
    chkId("rst2_seq0", 32'h3000, instOf(32'h3000), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
